// File: rtl/vga_fill.sv
// Rectangle fill into a 2-pixel-per-word framebuffer; full words are written directly, half words via read-modify-write.
// Start accepted in cycle T: busy from T+1, first access at T+2, done pulse at T+2+N (WR=1, RD+RMW=2 cycles per word).
module vga_fill #(
  parameter int H_PIX    = 160,
  parameter int V_PIX    = 120,
  parameter int FB_WORDS = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [7:0]  x1,
  input  logic [6:0]  y0,
  input  logic [6:0]  y1,
  input  logic [7:0]  color,
  output logic        busy,
  output logic        done,
  output logic [14:0] fb_addr,
  output logic        fb_we,
  output logic [15:0] fb_wdata,
  input  logic [15:0] fb_rdata
);

  localparam logic [7:0]  XMAX = 8'(H_PIX - 1);
  localparam logic [6:0]  YMAX = 7'(V_PIX - 1);
  localparam logic [14:0] WPR  = 15'(H_PIX / 2);
  localparam logic [15:0] FBW  = 16'(FB_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WR,
    S_RD,
    S_RMW,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  x0r_q, x0r_d, x1r_q, x1r_d;
  logic [6:0]  y0r_q, y0r_d, y1r_q, y1r_d;
  logic [7:0]  color_q, color_d;
  logic [7:0]  xlo_q, xlo_d, xhi_q, xhi_d;
  logic [6:0]  yhi_q, yhi_d;
  logic [6:0]  row_q, row_d;
  logic [14:0] base_q, base_d;
  logic [6:0]  col_q, col_d;
  logic        hi_q, hi_d;
  logic [14:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rmw_q, rmw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Normalised, clamped bounds derived from the latched request (used in SETUP)
  logic [7:0]  xa, xb, nxlo, nxhi;
  logic [6:0]  ya, yb, nylo, nyhi;

  always_comb begin
    xa   = (x0r_q > XMAX) ? XMAX : x0r_q;
    xb   = (x1r_q > XMAX) ? XMAX : x1r_q;
    ya   = (y0r_q > YMAX) ? YMAX : y0r_q;
    yb   = (y1r_q > YMAX) ? YMAX : y1r_q;
    nxlo = (xa <= xb) ? xa : xb;
    nxhi = (xa <= xb) ? xb : xa;
    nylo = (ya <= yb) ? ya : yb;
    nyhi = (ya <= yb) ? yb : ya;
  end

  logic        issue, finish, row_end, last;
  logic [7:0]  xlo_c, xhi_c;
  logic [6:0]  row_c, col_c;
  logic [14:0] base_c, cand_addr;
  logic [7:0]  pix_e, pix_o;
  logic        even_in, odd_in;

  always_comb begin
    state_d = state_q;
    x0r_d   = x0r_q;
    x1r_d   = x1r_q;
    y0r_d   = y0r_q;
    y1r_d   = y1r_q;
    color_d = color_q;
    xlo_d   = xlo_q;
    xhi_d   = xhi_q;
    yhi_d   = yhi_q;
    row_d   = row_q;
    base_d  = base_q;
    col_d   = col_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    rmw_d   = 1'b0;
    done_d  = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    xlo_c   = xlo_q;
    xhi_c   = xhi_q;

    // Candidate for the word after the current one; row wrap adds one row of words, no multiply
    row_end = (col_q == xhi_q[7:1]);
    last    = row_end && (row_q == yhi_q);
    if (row_end) begin
      row_c  = row_q + 7'd1;
      base_c = base_q + WPR;
      col_c  = xlo_q[7:1];
    end else begin
      row_c  = row_q;
      base_c = base_q;
      col_c  = col_q + 7'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0r_d   = x0;
          x1r_d   = x1;
          y0r_d   = y0;
          y1r_d   = y1;
          color_d = color;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        xlo_d  = nxlo;
        xhi_d  = nxhi;
        yhi_d  = nyhi;
        xlo_c  = nxlo;
        xhi_c  = nxhi;
        row_c  = nylo;
        base_c = 15'(nylo) * WPR;
        col_c  = nxlo[7:1];
        issue  = 1'b1;
      end
      S_WR, S_RMW: begin
        if (last) finish = 1'b1;
        else      issue  = 1'b1;
      end
      S_RD: begin
        we_d    = 1'b1;
        rmw_d   = 1'b1;
        state_d = S_RMW;
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cand_addr = base_c + {8'd0, col_c};
    pix_e     = {col_c, 1'b0};
    pix_o     = {col_c, 1'b1};
    even_in   = (pix_e >= xlo_c);
    odd_in    = (pix_o <= xhi_c);

    // Addresses only grow, so the first out-of-range word means nothing else is writable
    if (issue) begin
      if ({1'b0, cand_addr} >= FBW) begin
        finish = 1'b1;
      end else begin
        row_d  = row_c;
        base_d = base_c;
        col_d  = col_c;
        addr_d = cand_addr;
        if (even_in && odd_in) begin
          state_d = S_WR;
          we_d    = 1'b1;
          wdata_d = {color_q, color_q};
        end else begin
          state_d = S_RD;
          hi_d    = !even_in;
        end
      end
    end

    if (finish) begin
      state_d = S_FIN;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x0r_q   <= '0;
      x1r_q   <= '0;
      y0r_q   <= '0;
      y1r_q   <= '0;
      color_q <= '0;
      xlo_q   <= '0;
      xhi_q   <= '0;
      yhi_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      col_q   <= '0;
      hi_q    <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rmw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0r_q   <= x0r_d;
      x1r_q   <= x1r_d;
      y0r_q   <= y0r_d;
      y1r_q   <= y1r_d;
      color_q <= color_d;
      xlo_q   <= xlo_d;
      xhi_q   <= xhi_d;
      yhi_q   <= yhi_d;
      row_q   <= row_d;
      base_q  <= base_d;
      col_q   <= col_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rmw_q   <= rmw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Read data only arrives in the RMW cycle itself, so the merge sits after the register
  assign fb_wdata = rmw_q ? (hi_q ? {color_q, fb_rdata[7:0]} : {fb_rdata[15:8], color_q})
                          : wdata_q;
  assign fb_addr  = addr_q;
  assign fb_we    = we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
